led_gpio_ctrl: RTL



---
 rtl/led_gpio_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/led_gpio_ctrl.sv
// Memory-mapped LED peripheral on the nanorv32 native bus: set/clear/toggle
// LED bits atomically and blink selected LEDs from a shared prescaler.
module led_gpio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
  parameter int          NLED         = 4,
  parameter logic [15:0] PERIOD_RESET = 16'd50000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            mem_valid,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic [3:0]      mem_wstrb,
  output logic            mem_ready,
  output logic [31:0]     mem_rdata,
  output logic [NLED-1:0] led
);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  localparam logic [7:0] OFF_OUT    = 8'h00;
  localparam logic [7:0] OFF_SET    = 8'h04;
  localparam logic [7:0] OFF_CLR    = 8'h08;
  localparam logic [7:0] OFF_TGL    = 8'h0C;
  localparam logic [7:0] OFF_BLEN   = 8'h10;
  localparam logic [7:0] OFF_PERIOD = 8'h14;
  localparam logic [7:0] OFF_STAT   = 8'h18;

  state_t state, state_nxt;

  logic            sel;
  logic            access;
  logic            wr;
  logic [7:0]      offset;
  logic [NLED-1:0] wbits;

  logic [NLED-1:0] out_q, out_nxt;
  logic [NLED-1:0] blink_en_q, blink_en_nxt;
  logic [15:0]     period_q, period_nxt;
  logic            period_wr;
  logic [15:0]     presc_q;
  logic            phase_q;
  logic [31:0]     rd_val;
  logic [31:0]     rdata_q;
  logic [NLED-1:0] lit;

  logic unused_bits;
  assign unused_bits = ^{mem_wdata[31:16]};

  assign sel    = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign offset = mem_addr[7:0];
  assign wbits  = mem_wdata[NLED-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An access is performed on the edge that moves IDLE -> RESP; RESP always
  // returns to IDLE so ready can never be asserted on consecutive cycles.
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          state_nxt = RESP;
          access    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr        = access && (mem_wstrb != 4'b0000);
  assign mem_ready = (state == RESP);
  assign mem_rdata = rdata_q;

  always_comb begin
    out_nxt      = out_q;
    blink_en_nxt = blink_en_q;
    period_nxt   = period_q;
    period_wr    = 1'b0;
    if (wr) begin
      case (offset)
        OFF_OUT:  if (mem_wstrb[0]) out_nxt = wbits;
        OFF_SET:  if (mem_wstrb[0]) out_nxt = out_q | wbits;
        OFF_CLR:  if (mem_wstrb[0]) out_nxt = out_q & ~wbits;
        OFF_TGL:  if (mem_wstrb[0]) out_nxt = out_q ^ wbits;
        OFF_BLEN: if (mem_wstrb[0]) blink_en_nxt = wbits;
        OFF_PERIOD: begin
          if (mem_wstrb[0]) period_nxt[7:0]  = mem_wdata[7:0];
          if (mem_wstrb[1]) period_nxt[15:8] = mem_wdata[15:8];
          period_wr = |mem_wstrb[1:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'd0;
    case (offset)
      OFF_OUT:    rd_val[NLED-1:0] = out_q;
      OFF_BLEN:   rd_val[NLED-1:0] = blink_en_q;
      OFF_PERIOD: rd_val[15:0]     = period_q;
      OFF_STAT: begin
        rd_val[NLED-1:0] = ~led;
        rd_val[8]        = phase_q;
      end
      default: rd_val = 32'd0;
    endcase
  end

  // Read data is only held for the RESP cycle and is zero otherwise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q      <= '0;
      blink_en_q <= '0;
      period_q   <= PERIOD_RESET;
      rdata_q    <= 32'd0;
    end else begin
      out_q      <= out_nxt;
      blink_en_q <= blink_en_nxt;
      period_q   <= period_nxt;
      rdata_q    <= access ? rd_val : 32'd0;
    end
  end

  // A period write restarts the prescaler and wins over a terminal-count toggle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q <= PERIOD_RESET;
      phase_q <= 1'b1;
    end else if (period_wr) begin
      presc_q <= period_nxt;
      phase_q <= 1'b1;
    end else if (period_q == 16'd0) begin
      presc_q <= 16'd0;
      phase_q <= 1'b1;
    end else if (presc_q == 16'd0) begin
      presc_q <= period_q;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q - 16'd1;
    end
  end

  assign lit = out_q & ~(blink_en_q & {NLED{~phase_q}});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= '1;
    end else begin
      led <= ~lit;
    end
  end

endmodule
